laser_fire_seq: RTL and testbench
=================================

Name: laser_fire_seq

Overview:
- Parametrised laser-fire sequencer for N-channel emitter boards; next generation of the single-shot 8-channel laser controller.
- On each angle sync, fires one laser channel, or suppresses the shot, with a programmable pulse width and hold-off.
- Selects the channel by mode: round-robin, fixed, or round-robin skipping disabled channels.
- Drives the TDC channel mask from a runtime-writable per-channel table. Sits between the encoder angle-sync generator and the TDC front end.

Parameters:
CH_NUM, 8, number of laser channels (2..16)
CH_W, 4, width of channel index; must satisfy 2^CH_W >= CH_NUM
MASK_W, 8, TDC mask width per channel ({tdc2[3:0],tdc1[3:0]} by default)
PULSE_CYC, 1, laser strobe width in clocks (1..255)
HOLD_CYC, 4, dead time after strobe before re-arming (0..255)
MASK_INIT, {8'h0D,8'h0E,8'h0F,8'hC0,8'hD0,8'hE0,8'hF0,8'h0C}, flat CH_NUM*MASK_W reset table; entry 0 is the LSBs

Ports:
i_clk_100m  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_angle_sync  in  1  one-cycle shot request
i_cdctdc_ready  in  1  TDC ready to accept a shot
i_fire_mode  in  2  00 round-robin, 01 fixed, 10 skip-disabled, 11 reserved (behaves as 00)
i_laser_setnum  in  CH_W  channel for fixed mode
i_chnl_en  in  CH_NUM  per-channel enable (mode 10 only)
i_mask_we  in  1  mask table write strobe
i_mask_addr  in  CH_W  mask table address
i_mask_wdata  in  MASK_W  mask table data
o_laser_str  out  CH_NUM  one-hot laser strobe
o_laser_sync  out  1  one-cycle shot marker
o_tdc_chnlmask  out  MASK_W  mask of the last fired channel
o_laser_sernum  out  CH_W  index of the last fired channel
o_shot_err  out  1  one-cycle pulse on a suppressed shot
o_miss_cnt  out  16  syncs dropped while not armed, saturating
o_busy  out  1  high whenever the FSM is not in ST_READY

Behaviour:
- Reset values:
  - All outputs 0, except o_tdc_chnlmask = MASK_INIT entry 0.
  - FSM in ST_IDLE, round-robin pointer 0, table = MASK_INIT.
  - Reset mid-shot aborts immediately; o_laser_str drops asynchronously.
- FSM:
  - ST_IDLE -> ST_READY when i_cdctdc_ready = 1.
  - ST_READY -> ST_FIRE when i_angle_sync = 1.
  - ST_FIRE lasts PULSE_CYC clocks, then goes to ST_HOLD.
  - ST_HOLD lasts HOLD_CYC clocks, then goes to ST_IDLE. With HOLD_CYC = 0, ST_HOLD is skipped and ST_FIRE goes directly to ST_IDLE.
- Shot timing: sync sampled in ST_READY at cycle N.
  - o_laser_str is high for cycles N+1..N+PULSE_CYC.
  - o_laser_sync is high at N+1 only.
  - o_tdc_chnlmask and o_laser_sernum update at N+1 and hold until the next shot.
- Channel select, decided from inputs sampled at cycle N:
  - Mode 00/11: channel = pointer. Pointer then advances by 1 and wraps CH_NUM-1 -> 0.
  - Mode 01: channel = i_laser_setnum. Pointer is unchanged.
  - Mode 10: channel = first enabled channel at or after the pointer, searching with wrap. Pointer then becomes that channel+1, wrapped.
- Suppressed shot: mode 01 with setnum >= CH_NUM, or mode 10 with i_chnl_en = 0.
  - o_laser_str stays 0; o_laser_sync still pulses at N+1; o_shot_err pulses at N+1.
  - sernum, mask and pointer are unchanged.
  - The FSM still runs the ST_FIRE and ST_HOLD timing.
- Miss counter: i_angle_sync = 1 in any state other than ST_READY increments o_miss_cnt. It saturates at 16'hFFFF and is cleared only by reset.
- Mask table:
  - A write with i_mask_we = 1 commits at the next edge.
  - A write with addr >= CH_NUM is ignored.
  - A write to the entry being fired in the same cycle N: the shot uses the old value, and the new value is used from the next shot on.
- Mode and enable changes take effect only at the next sampled sync.

Test Plan:
- Mode 00, CH_NUM = 8, PULSE_CYC = 1, HOLD_CYC = 4, ready held high, 9 syncs 10 cycles apart -> o_laser_str = 01, 02, 04 … 80, 01; sernum 0..7, 0; mask 0C, F0, E0, D0, C0, 0F, 0E, 0D, 0C.
- Mode 01, setnum = 5, PULSE_CYC = 3 -> str = 20 for 3 cycles; sync high for the first cycle only; mask 0F. Then setnum = 9 -> str stays 0, sync = 1, shot_err = 1, sernum stays 5.
- Mode 10, chnl_en = 8'b1000_0100, pointer 0 -> shots on channels 2, 7, 2. Then chnl_en = 0 -> shot_err pulse.
- Sync during ST_FIRE/ST_HOLD, or with ready low, 3 times -> o_miss_cnt = 3 and no strobe. Force 65,540 misses -> o_miss_cnt = FFFF.
- Write addr 3 = 8'hAB in the same cycle as a sync firing channel 3 -> mask shows D0. The next channel-3 shot shows AB. A write to addr 12 is ignored.
- Assert i_rst_n low at cycle 2 of a PULSE_CYC = 5 strobe -> str = 0 immediately. After release: pointer 0, table = MASK_INIT, miss count 0.

Source files
------------

// File: rtl/laser_fire_seq.sv
// laser_fire_seq: angle-sync driven N-channel laser fire sequencer with runtime TDC mask table
module laser_fire_seq #(
    parameter int CH_NUM = 8,
    parameter int CH_W = 4,
    parameter int MASK_W = 8,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC = 4,
    parameter logic [CH_NUM*MASK_W-1:0] MASK_INIT = {8'h0D, 8'h0E, 8'h0F, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h0C}
) (
    input  logic              i_clk_100m,
    input  logic              i_rst_n,
    input  logic              i_angle_sync,
    input  logic              i_cdctdc_ready,
    input  logic [1:0]        i_fire_mode,
    input  logic [CH_W-1:0]   i_laser_setnum,
    input  logic [CH_NUM-1:0] i_chnl_en,
    input  logic              i_mask_we,
    input  logic [CH_W-1:0]   i_mask_addr,
    input  logic [MASK_W-1:0] i_mask_wdata,
    output logic [CH_NUM-1:0] o_laser_str,
    output logic              o_laser_sync,
    output logic [MASK_W-1:0] o_tdc_chnlmask,
    output logic [CH_W-1:0]   o_laser_sernum,
    output logic              o_shot_err,
    output logic [15:0]       o_miss_cnt,
    output logic              o_busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_FIRE, ST_HOLD} state_t;
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH_NUM);
    state_t            state;
    logic [7:0]        cnt;
    logic [CH_W-1:0]   ptr;
    logic [MASK_W-1:0] tbl [CH_NUM];
    logic              fixed_md, skip_md;
    logic              skip_hit, en_bit;
    logic [CH_W-1:0]   skip_ch;
    logic [CH_W:0]     idx;
    logic [CH_W-1:0]   sel_ch, ptr_nxt;
    logic              sel_ok;
    logic [MASK_W-1:0] sel_mask;
    function automatic logic [CH_W-1:0] inc(input logic [CH_W-1:0] x);
        return (x == CH_W'(CH_NUM-1)) ? '0 : x + CH_W'(1);
    endfunction
    assign fixed_md = (i_fire_mode == 2'b01);
    assign skip_md  = (i_fire_mode == 2'b10);
    always_comb begin
        skip_hit = 1'b0;
        skip_ch = '0;
        idx = '0;
        en_bit = 1'b0;
        for (int i = CH_NUM-1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (CH_W+1)'(i);
            idx = (idx >= CH_LIM) ? idx - CH_LIM : idx;
            en_bit = |(i_chnl_en & (CH_NUM'(1) << idx));
            skip_hit = skip_hit | en_bit;
            skip_ch = en_bit ? idx[CH_W-1:0] : skip_ch;
        end
    end
    assign sel_ch  = fixed_md ? i_laser_setnum : skip_md ? skip_ch : ptr;
    assign sel_ok  = fixed_md ? ({1'b0, i_laser_setnum} < CH_LIM) : skip_md ? skip_hit : 1'b1;
    assign ptr_nxt = fixed_md ? ptr : skip_md ? (skip_hit ? inc(skip_ch) : ptr) : inc(ptr);
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < CH_NUM; i++)
            sel_mask = (sel_ch == CH_W'(i)) ? tbl[i] : sel_mask;
    end
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CH_NUM; i++)
                tbl[i] <= MASK_INIT[i*MASK_W +: MASK_W];
        end else begin
            for (int i = 0; i < CH_NUM; i++)
                if (i_mask_we && i_mask_addr == CH_W'(i))
                    tbl[i] <= i_mask_wdata;
        end
    end
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            ptr            <= '0;
            o_laser_str    <= '0;
            o_laser_sync   <= 1'b0;
            o_shot_err     <= 1'b0;
            o_tdc_chnlmask <= MASK_INIT[MASK_W-1:0];
            o_laser_sernum <= '0;
            o_busy         <= 1'b0;
        end else begin
            o_laser_sync <= 1'b0;
            o_shot_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state  <= i_cdctdc_ready ? ST_READY : ST_IDLE;
                    o_busy <= !i_cdctdc_ready;
                end
                ST_READY: begin
                    o_busy <= i_angle_sync;
                    if (i_angle_sync) begin
                        state        <= ST_FIRE;
                        cnt          <= 8'(PULSE_CYC - 1);
                        o_laser_sync <= 1'b1;
                        o_shot_err   <= !sel_ok;
                        if (sel_ok) begin
                            o_laser_str    <= CH_NUM'(1) << sel_ch;
                            o_tdc_chnlmask <= sel_mask;
                            o_laser_sernum <= sel_ch;
                            ptr            <= ptr_nxt;
                        end
                    end
                end
                ST_FIRE: begin
                    o_busy <= 1'b1;
                    cnt    <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        o_laser_str <= '0;
                        state       <= (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
                        cnt         <= 8'(HOLD_CYC - 1);
                    end
                end
                default: begin
                    o_busy <= 1'b1;
                    cnt    <= cnt - 8'd1;
                    state  <= (cnt == 8'd0) ? ST_IDLE : ST_HOLD;
                end
            endcase
        end
    end
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n)
            o_miss_cnt <= '0;
        else if (i_angle_sync && state != ST_READY && o_miss_cnt != 16'hFFFF)
            o_miss_cnt <= o_miss_cnt + 16'd1;
    end
endmodule

// File: tb/tb_laser_fire_seq.sv
// tb_laser_fire_seq: directed checks of shot timing, channel modes, misses, mask table and reset
module tb_laser_fire_seq;
    logic        i_clk_100m = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_angle_sync = 1'b0;
    logic        i_cdctdc_ready = 1'b0;
    logic [1:0]  i_fire_mode = 2'b00;
    logic [3:0]  i_laser_setnum = 4'd0;
    logic [7:0]  i_chnl_en = 8'h00;
    logic        i_mask_we = 1'b0;
    logic [3:0]  i_mask_addr = 4'd0;
    logic [7:0]  i_mask_wdata = 8'h00;
    logic [7:0]  o_laser_str;
    logic        o_laser_sync;
    logic [7:0]  o_tdc_chnlmask;
    logic [3:0]  o_laser_sernum;
    logic        o_shot_err;
    logic [15:0] o_miss_cnt;
    logic        o_busy;
    int total = 0;
    int bad = 0;
    logic [7:0] rr_mask [9] = '{8'h0C, 8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'h0F, 8'h0E, 8'h0D, 8'h0C};

    laser_fire_seq #(.PULSE_CYC(3), .HOLD_CYC(4)) dut (
        .i_clk_100m(i_clk_100m), .i_rst_n(i_rst_n), .i_angle_sync(i_angle_sync),
        .i_cdctdc_ready(i_cdctdc_ready), .i_fire_mode(i_fire_mode), .i_laser_setnum(i_laser_setnum),
        .i_chnl_en(i_chnl_en), .i_mask_we(i_mask_we), .i_mask_addr(i_mask_addr),
        .i_mask_wdata(i_mask_wdata), .o_laser_str(o_laser_str), .o_laser_sync(o_laser_sync),
        .o_tdc_chnlmask(o_tdc_chnlmask), .o_laser_sernum(o_laser_sernum), .o_shot_err(o_shot_err),
        .o_miss_cnt(o_miss_cnt), .o_busy(o_busy)
    );

    always #5 i_clk_100m = ~i_clk_100m;

    task automatic step();
        @(posedge i_clk_100m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (o_busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("ready_timeout", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic shot(input logic [1:0] md, input logic [3:0] num, input logic [7:0] en);
        wait_ready();
        i_fire_mode = md;
        i_laser_setnum = num;
        i_chnl_en = en;
        i_angle_sync = 1'b1;
        step();
        i_angle_sync = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_str", o_laser_str, 8'h00);
        chk("rst_sync", o_laser_sync, 1'b0);
        chk("rst_mask", o_tdc_chnlmask, 8'h0C);
        chk("rst_sernum", o_laser_sernum, 4'd0);
        chk("rst_err", o_shot_err, 1'b0);
        chk("rst_miss", o_miss_cnt, 16'd0);
        chk("rst_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;
        i_cdctdc_ready = 1'b1;
        step();
        step();
        for (int k = 0; k < 9; k++) begin
            shot(2'b00, 4'd0, 8'h00);
            chk("rr_str", o_laser_str, 8'h01 << (k % 8));
            chk("rr_sync", o_laser_sync, 1'b1);
            chk("rr_sernum", o_laser_sernum, k % 8);
            chk("rr_mask", o_tdc_chnlmask, rr_mask[k]);
            chk("rr_err", o_shot_err, 1'b0);
        end
        shot(2'b01, 4'd5, 8'h00);
        chk("fix_str1", o_laser_str, 8'h20);
        chk("fix_sync1", o_laser_sync, 1'b1);
        chk("fix_mask", o_tdc_chnlmask, 8'h0F);
        chk("fix_sernum", o_laser_sernum, 4'd5);
        step();
        chk("fix_str2", o_laser_str, 8'h20);
        chk("fix_sync2", o_laser_sync, 1'b0);
        step();
        chk("fix_str3", o_laser_str, 8'h20);
        step();
        chk("fix_str4", o_laser_str, 8'h00);
        shot(2'b01, 4'd9, 8'h00);
        chk("bad_str", o_laser_str, 8'h00);
        chk("bad_sync", o_laser_sync, 1'b1);
        chk("bad_err", o_shot_err, 1'b1);
        chk("bad_sernum", o_laser_sernum, 4'd5);
        chk("bad_mask", o_tdc_chnlmask, 8'h0F);
        step();
        chk("bad_err_end", o_shot_err, 1'b0);
        shot(2'b10, 4'd0, 8'b1000_0100);
        chk("skip1_str", o_laser_str, 8'h04);
        chk("skip1_mask", o_tdc_chnlmask, 8'hE0);
        shot(2'b10, 4'd0, 8'b1000_0100);
        chk("skip2_str", o_laser_str, 8'h80);
        chk("skip2_sernum", o_laser_sernum, 4'd7);
        chk("skip2_mask", o_tdc_chnlmask, 8'h0D);
        shot(2'b10, 4'd0, 8'b1000_0100);
        chk("skip3_str", o_laser_str, 8'h04);
        chk("skip3_sernum", o_laser_sernum, 4'd2);
        shot(2'b10, 4'd0, 8'h00);
        chk("skip0_str", o_laser_str, 8'h00);
        chk("skip0_err", o_shot_err, 1'b1);
        chk("skip0_sernum", o_laser_sernum, 4'd2);
        shot(2'b00, 4'd0, 8'h00);
        chk("miss_shot_str", o_laser_str, 8'h08);
        chk("miss_shot_mask", o_tdc_chnlmask, 8'hD0);
        i_cdctdc_ready = 1'b0;
        i_angle_sync = 1'b1;
        step();
        i_angle_sync = 1'b0;
        chk("miss1_cnt", o_miss_cnt, 16'd1);
        chk("miss1_str", o_laser_str, 8'h08);
        chk("miss1_sernum", o_laser_sernum, 4'd3);
        step();
        step();
        chk("miss_str_end", o_laser_str, 8'h00);
        i_angle_sync = 1'b1;
        step();
        i_angle_sync = 1'b0;
        chk("miss2_cnt", o_miss_cnt, 16'd2);
        repeat (5) step();
        chk("idle_busy", o_busy, 1'b1);
        i_angle_sync = 1'b1;
        step();
        i_angle_sync = 1'b0;
        chk("miss3_cnt", o_miss_cnt, 16'd3);
        chk("miss3_str", o_laser_str, 8'h00);
        chk("miss3_sync", o_laser_sync, 1'b0);
        i_cdctdc_ready = 1'b1;
        wait_ready();
        i_mask_we = 1'b1;
        i_mask_addr = 4'd3;
        i_mask_wdata = 8'hAB;
        shot(2'b01, 4'd3, 8'h00);
        i_mask_we = 1'b0;
        chk("wr_same_mask", o_tdc_chnlmask, 8'hD0);
        chk("wr_same_sernum", o_laser_sernum, 4'd3);
        i_mask_we = 1'b1;
        i_mask_addr = 4'd12;
        i_mask_wdata = 8'h55;
        step();
        i_mask_we = 1'b0;
        shot(2'b01, 4'd3, 8'h00);
        chk("wr_next_mask", o_tdc_chnlmask, 8'hAB);
        shot(2'b01, 4'd4, 8'h00);
        chk("wr_oob_mask", o_tdc_chnlmask, 8'hC0);
        shot(2'b00, 4'd0, 8'h00);
        chk("pre_rst_str", o_laser_str, 8'h10);
        step();
        chk("pre_rst_str2", o_laser_str, 8'h10);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("async_str", o_laser_str, 8'h00);
        chk("async_mask", o_tdc_chnlmask, 8'h0C);
        chk("async_sernum", o_laser_sernum, 4'd0);
        step();
        i_rst_n = 1'b1;
        step();
        step();
        chk("post_rst_miss", o_miss_cnt, 16'd0);
        shot(2'b00, 4'd0, 8'h00);
        chk("post_rst_str", o_laser_str, 8'h01);
        chk("post_rst_mask", o_tdc_chnlmask, 8'h0C);
        shot(2'b01, 4'd3, 8'h00);
        chk("post_rst_tbl", o_tdc_chnlmask, 8'hD0);
        shot(2'b11, 4'd0, 8'h00);
        chk("mode11_str", o_laser_str, 8'h02);
        chk("mode11_sernum", o_laser_sernum, 4'd1);
        chk("mode11_mask", o_tdc_chnlmask, 8'hF0);
        i_cdctdc_ready = 1'b0;
        i_angle_sync = 1'b1;
        repeat (65534) step();
        chk("sat_fffe", o_miss_cnt, 16'hFFFE);
        step();
        chk("sat_ffff", o_miss_cnt, 16'hFFFF);
        repeat (5) step();
        chk("sat_hold", o_miss_cnt, 16'hFFFF);
        chk("sat_str", o_laser_str, 8'h00);
        i_angle_sync = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
